// File: rtl/enemy_fire_pkg.sv
// Shared types and pick helpers for the enemy fire scheduler.
package enemy_fire_pkg;

    localparam int unsigned COORD_W    = 10;
    localparam int unsigned PICK_W     = 32;
    localparam int unsigned PICK_IDX_W = 5;

    typedef enum logic [1:0] {IDLE, ARB, ISSUE} fire_state_t;

    typedef struct packed {
        logic                  valid;
        logic [PICK_IDX_W-1:0] idx;
    } pick_t;

    // First set bit scanning ptr, ptr+1, ... with wrap; callers zero-extend narrower masks.
    function automatic pick_t rr_pick(input logic [PICK_W-1:0] elig,
                                      input logic [PICK_IDX_W-1:0] ptr);
        pick_t hi;
        pick_t lo;
        hi = '0;
        lo = '0;
        for (int i = PICK_W - 1; i >= 0; i--) begin
            if (elig[i]) begin
                if (PICK_IDX_W'(i) >= ptr) begin
                    hi.valid = 1'b1;
                    hi.idx   = PICK_IDX_W'(i);
                end else begin
                    lo.valid = 1'b1;
                    lo.idx   = PICK_IDX_W'(i);
                end
            end
        end
        return hi.valid ? hi : lo;
    endfunction

    // Lowest set bit of a mask.
    function automatic pick_t lowest_free(input logic [PICK_W-1:0] mask);
        pick_t r;
        r = '0;
        for (int i = PICK_W - 1; i >= 0; i--) begin
            if (mask[i]) begin
                r.valid = 1'b1;
                r.idx   = PICK_IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/enemy_fire_scheduler_rr_arbiter.sv
// Combinational round-robin pick with an external priority pointer.
module rr_arbiter
    import enemy_fire_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] ptr,
    output logic          valid_c,
    output logic [IW-1:0] idx_c
);

    pick_t pick;

    // Delegate the scan to the shared package helper.
    assign pick    = rr_pick(PICK_W'(elig), PICK_IDX_W'(ptr));
    assign valid_c = pick.valid;
    assign idx_c   = IW'(pick.idx);

endmodule

// File: rtl/enemy_fire_scheduler.sv
// Per-frame round-robin binding of enemy launch requests to free bullet slots.
module enemy_fire_scheduler
    import enemy_fire_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned N_SLOT   = 3,
    parameter int unsigned COOLDOWN = 20
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     frame_clk,
    input  logic                     enable,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*COORD_W-1:0] req_x,
    input  logic [N_REQ*COORD_W-1:0] req_y,
    input  logic [N_SLOT-1:0]        slot_done,
    output logic [N_REQ-1:0]         grant,
    output logic [N_SLOT-1:0]        slot_fire,
    output logic [COORD_W-1:0]       fire_x,
    output logic [COORD_W-1:0]       fire_y,
    output logic [N_SLOT-1:0]        slot_busy
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CD_W  = $clog2(COOLDOWN + 1);

    fire_state_t        state;
    logic               frame_sync;
    logic               frame_dly;
    logic               fr_edge;
    logic [PTR_W-1:0]   rr_ptr;
    logic [CD_W-1:0]    cooldown [N_REQ];

    logic [N_REQ-1:0]   elig_c;
    logic [N_SLOT-1:0]  free_c;
    logic               win_valid_c;
    logic [PTR_W-1:0]   win_idx_c;
    pick_t              slot_pick_c;
    logic [N_REQ-1:0]   grant_oh_c;
    logic [N_SLOT-1:0]  slot_oh_c;
    logic [COORD_W-1:0] x_arr_c [N_REQ];
    logic [COORD_W-1:0] y_arr_c [N_REQ];

    // Eligibility and unpacked coordinate views.
    always_comb begin
        for (int i = 0; i < int'(N_REQ); i++) begin
            elig_c[i]  = req[i] & (cooldown[i] == '0) & enable;
            x_arr_c[i] = req_x[i*COORD_W +: COORD_W];
            y_arr_c[i] = req_y[i*COORD_W +: COORD_W];
        end
    end

    rr_arbiter #(.N(N_REQ)) u_rr_arbiter (
        .elig    (elig_c),
        .ptr     (rr_ptr),
        .valid_c (win_valid_c),
        .idx_c   (win_idx_c)
    );

    assign free_c      = ~slot_busy;
    assign slot_pick_c = lowest_free(PICK_W'(free_c));
    assign grant_oh_c  = N_REQ'(1) << win_idx_c;
    assign slot_oh_c   = N_SLOT'(1) << slot_pick_c.idx;

    // Frame edge detect, cooldowns, slot occupancy and the IDLE/ARB/ISSUE sequencer.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            frame_sync <= 1'b0;
            frame_dly  <= 1'b0;
            fr_edge    <= 1'b0;
            rr_ptr     <= '0;
            grant      <= '0;
            slot_fire  <= '0;
            fire_x     <= '0;
            fire_y     <= '0;
            slot_busy  <= '0;
            for (int i = 0; i < int'(N_REQ); i++) cooldown[i] <= '0;
        end else begin
            // Extra flop ahead of the edge detector because frame_clk is asynchronous.
            frame_sync <= frame_clk;
            frame_dly  <= frame_sync;
            fr_edge    <= frame_sync & ~frame_dly;
            grant      <= '0;
            slot_fire  <= '0;
            slot_busy  <= slot_busy & ~slot_done;
            case (state)
                IDLE: begin
                    if (fr_edge) begin
                        state <= ARB;
                        for (int i = 0; i < int'(N_REQ); i++) begin
                            if (cooldown[i] != '0) cooldown[i] <= cooldown[i] - CD_W'(1);
                        end
                    end
                end
                ARB: begin
                    state <= IDLE;
                    if (win_valid_c && slot_pick_c.valid) begin
                        state               <= ISSUE;
                        grant               <= grant_oh_c;
                        slot_fire           <= slot_oh_c;
                        fire_x              <= x_arr_c[win_idx_c];
                        fire_y              <= y_arr_c[win_idx_c];
                        slot_busy           <= (slot_busy & ~slot_done) | slot_oh_c;
                        cooldown[win_idx_c] <= CD_W'(COOLDOWN);
                        rr_ptr              <= (win_idx_c == PTR_W'(N_REQ - 1)) ? '0
                                                                               : win_idx_c + PTR_W'(1);
                    end
                end
                ISSUE:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// Directed self-checking bench for enemy_fire_scheduler.
module tb_enemy_fire_scheduler;

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned N_SLOT = 3;
    localparam logic [7:0]  STD    = 8'b0000_1111;
    localparam logic [7:0]  DBL    = 8'b0000_0101;

    logic                Clk;
    logic                Reset;
    logic                frame_clk;
    logic                enable;
    logic [N_REQ-1:0]    req;
    logic [N_REQ*10-1:0] req_x;
    logic [N_REQ*10-1:0] req_y;
    logic [N_SLOT-1:0]   slot_done;
    logic [N_REQ-1:0]    grant;
    logic [N_SLOT-1:0]   slot_fire;
    logic [9:0]          fire_x;
    logic [9:0]          fire_y;
    logic [N_SLOT-1:0]   slot_busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [N_REQ-1:0]  cap_grant;
    logic [N_SLOT-1:0] cap_fire;
    logic [9:0]        cap_x;
    logic [9:0]        cap_y;
    logic [N_SLOT-1:0] cap_busy;
    int                n_pulses;
    int                early;

    enemy_fire_scheduler #(.N_REQ(4), .N_SLOT(3), .COOLDOWN(20)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .enable    (enable),
        .req       (req),
        .req_x     (req_x),
        .req_y     (req_y),
        .slot_done (slot_done),
        .grant     (grant),
        .slot_fire (slot_fire),
        .fire_x    (fire_x),
        .fire_y    (fire_y),
        .slot_busy (slot_busy)
    );

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic set_xy(input int i, input int x, input int y);
        req_x[i*10 +: 10] = 10'(x);
        req_y[i*10 +: 10] = 10'(y);
    endtask

    // One 8-cycle frame window; outputs are captured 4 cycles after the rise.
    task automatic run_frame(input logic [7:0] pat);
        n_pulses = 0;
        for (int t = 0; t < 8; t++) begin
            frame_clk = pat[t];
            tick();
            if (t == 3) begin
                cap_grant = grant;
                cap_fire  = slot_fire;
                cap_x     = fire_x;
                cap_y     = fire_y;
                cap_busy  = slot_busy;
            end
            if (grant != '0 || slot_fire != '0) n_pulses++;
        end
        frame_clk = 1'b0;
    endtask

    // 19 frames that must produce nothing, then one more frame left in the captures.
    task automatic cd_window();
        early = 0;
        for (int f = 0; f < 19; f++) begin
            run_frame(STD);
            early += n_pulses;
        end
        run_frame(STD);
    endtask

    task automatic do_reset();
        Reset     = 1'b0;
        frame_clk = 1'b0;
        slot_done = '0;
        tick();
        tick();
        Reset = 1'b1;
        tick();
    endtask

    task automatic pulse_done(input logic [N_SLOT-1:0] m);
        slot_done = m;
        tick();
        slot_done = '0;
        tick();
    endtask

    initial begin
        Reset     = 1'b0;
        frame_clk = 1'b0;
        enable    = 1'b0;
        req       = '0;
        req_x     = '0;
        req_y     = '0;
        slot_done = '0;
        tick();
        tick();
        check("reset_outputs", 32'({grant, slot_fire, fire_x, fire_y, slot_busy}), 32'd0);
        Reset = 1'b1;
        tick();

        // Single requester, first grant and its cooldown window.
        enable = 1'b1;
        req    = 4'b0001;
        set_xy(0, 600, 20);
        run_frame(STD);
        check("t1_grant", 32'(cap_grant), 32'b0001);
        check("t1_slot_fire", 32'(cap_fire), 32'b001);
        check("t1_fire_x", 32'(cap_x), 32'd600);
        check("t1_fire_y", 32'(cap_y), 32'd20);
        check("t1_busy", 32'(cap_busy), 32'b001);
        check("t1_pulse_count", 32'(n_pulses), 32'd1);
        pulse_done(3'b100);
        check("t1_done_on_free_slot", 32'(slot_busy), 32'b001);
        cd_window();
        check("t1_no_grant_in_cooldown", 32'(early), 32'd0);
        check("t1_grant_after_cooldown", 32'(cap_grant), 32'b0001);
        check("t1_second_slot", 32'(cap_fire), 32'b010);

        // All four requesting: round-robin across planes, lowest free slot each time.
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 4; i++) set_xy(i, 100 + i, 200 + i);
        for (int k = 0; k < 3; k++) begin
            run_frame(STD);
            check("t2_grant", 32'(cap_grant), 32'(1) << k);
            check("t2_slot_fire", 32'(cap_fire), 32'(1) << k);
            check("t2_fire_x", 32'(cap_x), 32'(100 + k));
            check("t2_pulse_count", 32'(n_pulses), 32'd1);
        end
        check("t2_all_busy", 32'(slot_busy), 32'b111);

        // Pool exhausted: requests wait until a slot is released.
        req   = 4'b1000;
        early = 0;
        for (int f = 0; f < 5; f++) begin
            run_frame(STD);
            early += n_pulses;
        end
        check("t3_no_grant_when_full", 32'(early), 32'd0);
        pulse_done(3'b010);
        check("t3_busy_after_done", 32'(slot_busy), 32'b101);
        run_frame(STD);
        check("t3_grant", 32'(cap_grant), 32'b1000);
        check("t3_slot_fire", 32'(cap_fire), 32'b010);
        check("t3_fire_y", 32'(cap_y), 32'd203);
        check("t3_busy", 32'(cap_busy), 32'b111);

        // Held request from plane 1 across its cooldown.
        do_reset();
        req = 4'b0010;
        run_frame(STD);
        check("t4_first_grant", 32'(cap_grant), 32'b0010);
        check("t4_first_slot", 32'(cap_fire), 32'b001);
        cd_window();
        check("t4_no_grant_in_cooldown", 32'(early), 32'd0);
        check("t4_grant_at_f20", 32'(cap_grant), 32'b0010);
        check("t4_slot_at_f20", 32'(cap_fire), 32'b010);

        // Disabled: no grants, cooldowns still run down.
        do_reset();
        req = 4'b0001;
        run_frame(STD);
        check("t5_prime_grant", 32'(cap_grant), 32'b0001);
        enable = 1'b0;
        req    = 4'b0011;
        early  = 0;
        for (int f = 0; f < 20; f++) begin
            run_frame(STD);
            early += n_pulses;
        end
        check("t5_no_grant_disabled", 32'(early), 32'd0);
        enable = 1'b1;
        run_frame(STD);
        check("t5_grant_on_enable", 32'(cap_grant), 32'b0010);
        check("t5_slot_on_enable", 32'(cap_fire), 32'b010);
        run_frame(STD);
        check("t5_cooldown_ran_while_off", 32'(cap_grant), 32'b0001);
        check("t5_slot_third", 32'(cap_fire), 32'b100);

        // Reset asserted while a grant is on the outputs.
        do_reset();
        req = 4'b0001;
        set_xy(0, 600, 20);
        for (int t = 0; t < 4; t++) begin
            frame_clk = STD[t];
            tick();
        end
        check("t6_grant_before_reset", 32'(grant), 32'b0001);
        Reset = 1'b0;
        #1;
        check("t6_reset_mid_issue", 32'({grant, slot_fire, fire_x, fire_y, slot_busy}), 32'd0);
        frame_clk = 1'b0;
        tick();
        tick();
        Reset = 1'b1;
        tick();
        run_frame(STD);
        check("t6_fresh_after_reset", 32'({cap_grant, cap_fire, cap_busy}), 32'({4'b0001, 3'b001, 3'b001}));

        // Second frame edge while the FSM is busy is dropped entirely.
        do_reset();
        req = 4'b0011;
        run_frame(DBL);
        check("t6_double_edge_pulses", 32'(n_pulses), 32'd1);
        check("t6_double_edge_grant", 32'(cap_grant), 32'b0001);
        req = 4'b0001;
        cd_window();
        check("t6_no_extra_decrement", 32'(early), 32'd0);
        check("t6_grant_after_window", 32'(cap_grant), 32'b0001);
        check("t6_slot_after_window", 32'(cap_fire), 32'b010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/enemy_fire_scheduler.md
Name: enemy_fire_scheduler

Overview:
Shares a small pool of enemy-bullet slots among several enemy plane instances that each raise a launch request. Once per frame it picks at most one requester, round-robin, and binds it to the lowest free bullet slot. It hands that slot the requester's start coordinates and applies a per-plane cooldown. It sits between the enemy plane modules (launch, start_x, start_y) and the enemy bullet modules.

Parameters:
N_REQ, 4, number of enemy plane requesters.
N_SLOT, 3, number of enemy bullet slots.
COOLDOWN, 20, frames a plane must wait after a grant before it is eligible again.

Ports:
Clk  in  1  50 MHz system clock.
Reset  in  1  asynchronous, active-low reset.
frame_clk  in  1  frame strobe, ~60 Hz, asynchronous to decisions; edge-detected internally.
enable  in  1  game/level active; 0 blocks new grants.
req  in  N_REQ  per-plane launch request, level.
req_x  in  N_REQ*10  per-plane start_x, packed, plane i at [10i+9:10i].
req_y  in  N_REQ*10  per-plane start_y, packed, same layout as req_x.
slot_done  in  N_SLOT  pulse from a bullet slot: bullet left the screen or hit something; frees the slot.
grant  out  N_REQ  one-hot, 1-cycle pulse to the granted plane.
slot_fire  out  N_SLOT  one-hot, 1-cycle pulse to the chosen bullet slot.
fire_x  out  10  start X for the fired slot; holds its value between fires.
fire_y  out  10  start Y for the fired slot; holds its value between fires.
slot_busy  out  N_SLOT  registered occupancy per slot.

Behaviour:
- Reset (async, Reset=0): all outputs 0; busy=0; all cooldowns=0; rr_ptr=0; state IDLE; edge-detect flops=0.
- Frame edge detection:
  - frame_clk_delayed <= frame_clk; fr_edge <= frame_clk & ~frame_clk_delayed.
  - fr_edge is a 1-cycle pulse, 2 Clk cycles after the rise.
- Cooldown:
  - On every fr_edge, each nonzero cooldown[i] decrements by 1, saturating at 0.
  - Counting continues regardless of enable.
  - Width is $clog2(COOLDOWN+1).
- Eligibility:
  - elig[i] = req[i] & (cooldown[i]==0) & enable.
  - free = ~busy.
- FSM, states IDLE, ARB, ISSUE:
  - IDLE: on fr_edge go to ARB. Cooldown decrement happens in this same cycle.
  - ARB (1 cycle):
    - Evaluate elig using the post-decrement cooldown (registered value in ARB).
    - If any elig and any free: pick winner = first elig index scanning rr_ptr, rr_ptr+1, … mod N_REQ. Pick slot = lowest-index free bit.
    - Latch winner, slot, req_x[winner], req_y[winner]. Go to ISSUE.
    - Otherwise go to IDLE with no outputs.
  - ISSUE (1 cycle):
    - grant[winner]=1, slot_fire[slot]=1.
    - fire_x/fire_y take the latched values, driven from registers and valid the same cycle.
    - busy[slot]<=1; cooldown[winner]<=COOLDOWN; rr_ptr<=(winner+1) mod N_REQ.
    - Go to IDLE.
- Latency: frame_clk rise to grant/slot_fire pulse is 4 Clk cycles.
- At most one grant per frame. grant and slot_fire are always asserted together, one-hot, never otherwise.
- slot_done[s]: clears busy[s] on the next edge, in any state.
  - slot_done on an already-free slot is ignored.
  - If slot_done[s] arrives during ARB, slot s is not considered free until the following frame.
  - Simultaneous slot_done[s] and busy-set of s cannot occur, because only free slots are chosen.
- fr_edge while in ARB/ISSUE: dropped, including its cooldown decrement. This cannot occur at real frame rates; the bench must still check it.
- All slots busy: requests wait. There is no queue; a plane must still be requesting on a later frame.
- enable falling mid-ARB: the ARB decision uses that cycle's enable. An ISSUE already entered completes.
- Reset mid-operation: immediate return to reset values; any pending ISSUE is lost.

Decomposition:
- Package enemy_fire_pkg holds:
  - typedef enum logic [1:0] {IDLE, ARB, ISSUE} fire_state_t;
  - function rr_pick(elig, ptr) returning index + valid;
  - function lowest_free(mask).
- One natural sub-module: rr_arbiter, a parameterised round-robin pick with pointer input. It is reusable for the sprite ROM port sharing.

Test Plan:
1. Reset, enable=1, req=4'b0001, req_x[0]=600, req_y[0]=20, one frame → 4 cycles after the rise: grant=0001, slot_fire=001, fire_x=600, fire_y=20, slot_busy=001; no further grant to plane 0 for 20 frames.
2. req=4'b1111, all cooldowns 0, over 3 consecutive frames → grants go to 0, then 1, then 2, each 1-cycle one-hot; slots 0, 1, 2; slot_busy=111.
3. All slots busy, req=4'b1000 over 5 frames → no grant. Pulse slot_done=010 → on the next frame grant=1000, slot_fire=010.
4. Plane 1 granted at frame F and req held high → no grant to plane 1 at frames F+1 through F+19; grant at F+20, provided a slot is free.
5. enable=0 with req=4'b0011 → no grant, but cooldowns keep decrementing. Raise enable → grant on the next frame edge.
6. Assert Reset low during ISSUE → grant/slot_fire drop immediately and all registers read 0. An extra frame_clk pulse injected during ARB produces neither a second grant nor an extra decrement.
